// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   slave  : hazard controller side (register ids / control in, selects out)
//   master : pipeline side (drives ids / control, consumes selects)
// Signal names follow the pipeline's own naming (RS1_D, ForwardAE, ...).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       RS1_D, RS2_D, RS1_E, RS2_E;
  logic [4:0]       RD_E, RD_M, RDW;
  logic             ResultSrcE, RegWriteM, RegWriteW, PCSrcE;
  logic             dmem_stall, halt_req;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             halt_ack;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RDW,
    input  ResultSrcE, RegWriteM, RegWriteW, PCSrcE, dmem_stall, halt_req,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, halt_ack, stall_cnt, flush_cnt
  );

  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RDW,
    output ResultSrcE, RegWriteM, RegWriteW, PCSrcE, dmem_stall, halt_req,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, halt_ack, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard / sequencing control for the 5-stage RV32I pipeline.
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous reset, active low
//   hz   : hazard_ctrl_if.slave -- register ids, load/branch/mem-wait/halt
//          inputs; forwarding selects, stall/flush enables, halt_ack and
//          perf counters out.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall_cnt / flush_cnt counters; otherwise both ports read 0.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic        clk,
  input logic        rst,
  hazard_ctrl_if.slave hz
);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_lw_stall, w_stop_fetch;

  // M stage wins over W: it holds the younger result.
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                     input logic wm, input logic [4:0] rdw,
                                     input logic ww);
    if (wm && rdm != 5'd0 && rdm == rs)      fwd = 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) fwd = 2'b01;
    else                                     fwd = 2'b00;
  endfunction

  assign hz.ForwardAE = fwd(hz.RS1_E, hz.RD_M, hz.RegWriteM, hz.RDW, hz.RegWriteW);
  assign hz.ForwardBE = fwd(hz.RS2_E, hz.RD_M, hz.RegWriteM, hz.RDW, hz.RegWriteW);

  assign w_lw_stall = hz.ResultSrcE && hz.RD_E != 5'd0 &&
                      (hz.RD_E == hz.RS1_D || hz.RD_E == hz.RS2_D);

  // Fetch is shut off from the very cycle halt_req is seen, so no new
  // instruction enters behind the drain.
  assign w_stop_fetch = (r_state != S_RUN) || hz.halt_req;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: if (hz.halt_req) begin
        w_state_nxt = S_DRAIN;
        w_cnt_nxt   = '0;
      end
      S_DRAIN: begin
        if (!hz.halt_req)         w_state_nxt = S_RUN;
        else if (!hz.dmem_stall) begin
          if (r_cnt == LAST)      w_state_nxt = S_HALTED;
          else                    w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_HALTED: if (!hz.halt_req) w_state_nxt = S_RUN;
      default:                    w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    hz.StallF = w_lw_stall || w_stop_fetch;
    hz.StallD = w_lw_stall;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = hz.PCSrcE || w_stop_fetch;
    hz.FlushE = w_lw_stall || hz.PCSrcE;
    hz.FlushW = 1'b0;
    // A redirect while draining must still land in PC, else the resume
    // address would be lost.
    if (hz.PCSrcE && r_state != S_HALTED) hz.StallF = 1'b0;
    // Memory wait freezes everything up to M and bubbles W; it overrides
    // all other requests for the cycle.
    if (hz.dmem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b1;
    end
  end

  assign hz.halt_ack = (r_state == S_HALTED);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_lw_stall || hz.dmem_stall) && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (hz.PCSrcE && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and sequencing controller for the five-stage RV32I pipeline. It drives the forwarding selects (ForwardA_E/ForwardB_E) into the execute stage and the per-stage stall/flush enables. It handles load-use stalls, taken-branch flushes and data-memory wait states. It also drains the pipeline on an external halt request and acknowledges when the machine is empty.

## Interface
Parameters:
- DRAIN_CYCLES, 4: bubble cycles inserted before halt_ack (one per stage behind fetch).
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RS1_D, RS2_D  in  5  source registers of instruction in decode.
- RS1_E, RS2_E  in  5  source registers of instruction in execute.
- RD_E, RD_M, RDW  in  5  destination registers in E/M/W.
- ResultSrcE  in  1  1 = instruction in E is a load.
- RegWriteM, RegWriteW  in  1  write enables in M/W.
- PCSrcE  in  1  taken branch/jump resolved in E.
- dmem_stall  in  1  data memory not ready this cycle.
- halt_req  in  1  level request to stop and drain.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALU_ResultM.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  load a bubble into the corresponding register.
- halt_ack  out  1  pipeline empty and halted.
- stall_cnt, flush_cnt  out  CNT_W  performance counters (see Configuration).

## Operation
- Forwarding (A; B identical with RS2_E):
  - 10 if RegWriteM && RD_M != 0 && RD_M == RS1_E.
  - else 01 if RegWriteW && RDW != 0 && RDW == RS1_E.
  - else 00.
  - M has priority over W.
- Load-use: lw_stall = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D).
  - Response: StallF = StallD = 1, FlushE = 1.
- Branch: PCSrcE causes FlushD = FlushE = 1. PCSrcE and lw_stall cannot both be true, since the instruction in E is either a load or a branch.
- Memory wait: dmem_stall causes StallF/D/E/M = 1 and FlushW = 1. All other stall and flush terms are masked for that cycle. The drain counter holds.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when halt_req = 1. The counter loads 0.
  - DRAIN: StallF = 1 and FlushD = 1 every cycle. The counter increments on cycles with dmem_stall = 0.
    - When the counter reaches DRAIN_CYCLES-1 and no memory wait is present, go to HALTED.
    - If halt_req drops, return to RUN next cycle with no ack.
    - If PCSrcE = 1 in DRAIN, StallF is forced 0 for that cycle so the redirect target is captured in PC. FlushD stays 1.
  - HALTED: halt_ack = 1, StallF = 1, FlushD = 1. Go to RUN on halt_req = 0.

## Timing
- Forward, stall and flush outputs are combinational from inputs and the registered state. There is no added latency.
- halt_ack is decoded from the registered state.
  - It rises DRAIN_CYCLES + 1 clocks after halt_req is sampled, assuming no memory waits.
  - It falls one clock after halt_req is sampled low.
- Reset values:
  - state = RUN, drain counter = 0, halt_ack = 0, stall_cnt = flush_cnt = 0.
  - With all inputs 0, every stall, flush and forward output is 0.
- Asserting rst mid-DRAIN or mid-HALTED returns immediately to RUN with ack 0.
- dmem_stall during HALTED has no effect on state.

## Configuration
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with lw_stall || dmem_stall.
  - flush_cnt increments on every cycle with PCSrcE.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: no counter registers are built. stall_cnt and flush_cnt are tied to 0, and the ports remain for interface stability.

## Test plan
- Forwarding:
  - RegWriteM = 1, RD_M = 5, RDW = 5, RegWriteW = 1, RS1_E = 5 -> ForwardAE = 10.
  - Same with RD_M = 0 -> ForwardAE = 01.
  - RS2_E = 0 with matching RDs -> ForwardBE = 00.
- Load-use: ResultSrcE = 1, RD_E = 7, RS2_D = 7 -> StallF = StallD = FlushE = 1 for exactly that cycle. stall_cnt +1 when the macro is defined.
- Branch plus memory wait:
  - PCSrcE = 1 -> FlushD = FlushE = 1.
  - Same cycle with dmem_stall = 1 -> FlushD = FlushE = 0, StallF..StallM = 1, FlushW = 1.
- Halt:
  - halt_req = 1 held -> halt_ack = 1 at cycle 5. StallF and FlushD are high from cycle 0.
  - Drop halt_req -> ack 0 next cycle, state RUN.
- Drain interactions:
  - dmem_stall high 3 cycles during DRAIN -> ack delayed by 3 cycles.
  - PCSrcE in DRAIN -> StallF = 0 that cycle.
  - rst low mid-DRAIN -> ack 0 and counters 0 immediately.
